// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 digest output path.
package sha256_pkg;

  localparam int unsigned DIGEST_W = 256;
  localparam logic [7:0]  ASCII_CR = 8'h0D;
  localparam logic [7:0]  ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sha256_digest_tx_if.sv
// Digest capture request in, byte stream out, plus status pulses.
interface sha256_digest_tx_if;
  import sha256_pkg::*;

  logic [DIGEST_W-1:0] digest_in;
  logic                digest_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                done;
  logic                overrun;

  modport master (
    output digest_in, digest_valid, tx_ready,
    input  tx_data, tx_valid, busy, done, overrun
  );

  modport slave (
    input  digest_in, digest_valid, tx_ready,
    output tx_data, tx_valid, busy, done, overrun
  );

endinterface

// File: rtl/sha256_digest_tx_hex_nibble_enc.sv
// Combinational nibble to lowercase ASCII hex character.
module hex_nibble_enc (
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nib < 4'd10) o_ascii = 8'h30 + {4'h0, i_nib};
    else               o_ascii = 8'h57 + {4'h0, i_nib};
  end

endmodule

// File: rtl/sha256_digest_tx.sv
// Captures the final digest and streams it MSB-first as hex ASCII or raw bytes.
// state | meaning
// IDLE  | waiting for digest_valid
// DATA  | emitting digest elements
// CR    | emitting 0x0D
// LF    | emitting 0x0A
module sha256_digest_tx
  import sha256_pkg::*;
#(
  parameter bit HEX_ASCII   = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input logic               clk,
  input logic               rst,
  sha256_digest_tx_if.slave bus
);

  localparam int unsigned EW       = HEX_ASCII ? 4 : 8;
  localparam logic [6:0]  LAST_CNT = HEX_ASCII ? 7'd63 : 7'd31;

  tx_state_t           r_state, w_state_nx;
  logic [DIGEST_W-1:0] r_shift, w_shift_nx;
  logic [6:0]          r_cnt, w_cnt_nx;
  logic [7:0]          r_tx_data, w_tx_data_nx;
  logic                r_tx_valid, w_tx_valid_nx;
  logic                r_busy, w_busy_nx;
  logic                r_done, w_done_nx;
  logic                r_overrun, w_overrun_nx;

  logic [EW-1:0] w_top;
  logic [7:0]    w_elem;
  logic          w_hs;

  // tx_data is registered, so the encoder looks one element ahead: the
  // incoming digest at capture, otherwise the element after the shift.
  assign w_top = (r_state == IDLE) ? bus.digest_in[DIGEST_W-1 -: EW]
                                   : r_shift[DIGEST_W-1-EW -: EW];

  generate
    if (HEX_ASCII) begin : g_hex
      hex_nibble_enc u_enc (.i_nib(w_top), .o_ascii(w_elem));
    end else begin : g_raw
      assign w_elem = w_top;
    end
  endgenerate

  assign w_hs = r_tx_valid & bus.tx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_cnt      <= w_cnt_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_overrun  <= w_overrun_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_cnt_nx      = r_cnt;
    w_tx_data_nx  = r_tx_data;
    w_tx_valid_nx = r_tx_valid;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    w_overrun_nx  = bus.digest_valid && (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (bus.digest_valid) begin
          w_shift_nx    = bus.digest_in;
          w_cnt_nx      = '0;
          w_tx_data_nx  = w_elem;
          w_tx_valid_nx = 1'b1;
          w_busy_nx     = 1'b1;
          w_state_nx    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          w_shift_nx = r_shift << EW;
          w_cnt_nx   = r_cnt + 7'd1;
          if (r_cnt != LAST_CNT) begin
            w_tx_data_nx = w_elem;
          end else if (APPEND_CRLF) begin
            w_tx_data_nx = ASCII_CR;
            w_state_nx   = CR;
          end else begin
            w_tx_valid_nx = 1'b0;
            w_busy_nx     = 1'b0;
            w_done_nx     = 1'b1;
            w_state_nx    = IDLE;
          end
        end
      end
      CR: begin
        if (w_hs) begin
          w_tx_data_nx = ASCII_LF;
          w_state_nx   = LF;
        end
      end
      LF: begin
        if (w_hs) begin
          w_tx_valid_nx = 1'b0;
          w_busy_nx     = 1'b0;
          w_done_nx     = 1'b1;
          w_state_nx    = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Scoreboard bench: a hex+CRLF instance and a raw-only instance of the digest serializer.
module tb_sha256_digest_tx;

  localparam logic [255:0] ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ZERO = '0;
  localparam logic [255:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_digest_tx_if bus0 ();
  sha256_digest_tx_if bus1 ();

  sha256_digest_tx u_dut_hex (.clk(clk), .rst(rst), .bus(bus0.slave));
  sha256_digest_tx #(.HEX_ASCII(1'b0), .APPEND_CRLF(1'b0))
    u_dut_raw (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int hs0 = 0, hs1 = 0;
  int done0_cnt = 0, done0_cyc = 0, done1_cyc = 0, ovr0 = 0;
  bit stall0 = 1'b0;
  logic [7:0] prev0 = 8'h00;
  bit rdy_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
  endfunction

  task automatic push_frame(input int which, input logic [255:0] d, input bit hex, input bit crlf);
    logic [7:0] b;
    int n;
    n = hex ? 64 : 32;
    for (int i = 0; i < n; i++) begin
      b = hex ? hexc(d[255-4*i -: 4]) : d[255-8*i -: 8];
      if (which == 0) q0.push_back(b); else q1.push_back(b);
    end
    if (crlf) begin
      if (which == 0) begin q0.push_back(8'h0D); q0.push_back(8'h0A); end
      else            begin q1.push_back(8'h0D); q1.push_back(8'h0A); end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus0.tx_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        chk("stall_data", bus0.tx_data, prev0);
        chk("stall_valid", bus0.tx_valid, 1);
      end
      if (bus0.tx_valid && bus0.tx_ready) begin
        if (q0.size() == 0) chk("extra_byte_hex", q0.size(), 1);
        else                chk("byte_hex", bus0.tx_data, q0.pop_front());
        hs0++;
      end
      stall0 = bus0.tx_valid && !bus0.tx_ready;
      prev0  = bus0.tx_data;
      if (bus0.done) begin done0_cnt++; done0_cyc = cyc; end
      if (bus0.overrun) ovr0++;
      if (bus1.tx_valid && bus1.tx_ready) begin
        if (q1.size() == 0) chk("extra_byte_raw", q1.size(), 1);
        else                chk("byte_raw", bus1.tx_data, q1.pop_front());
        hs1++;
      end
      if (bus1.done) done1_cyc = cyc;
    end
  end

  task automatic cap0(input logic [255:0] d);
    bus0.digest_in    = d;
    bus0.digest_valid = 1'b1;
    @(posedge clk); #1;
    bus0.digest_valid = 1'b0;
  endtask

  task automatic wait_done0(input string tag, input int budget);
    int d;
    d = done0_cnt;
    for (int i = 0; i < budget && done0_cnt == d; i++) @(posedge clk);
    #1;
    chk(tag, done0_cnt - d, 1);
  endtask

  task automatic wait_hs0(input string tag, input int start, input int n);
    for (int i = 0; i < 300 && (hs0 - start) < n; i++) @(posedge clk) #1;
    chk(tag, hs0 - start, n);
  endtask

  initial begin
    int c_e, hs_s, hs1_s, ovr_s, d_s;
    bus0.digest_in = '0; bus0.digest_valid = 1'b0;
    bus1.digest_in = '0; bus1.digest_valid = 1'b0; bus1.tx_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus0.tx_valid, 0);
    chk("rst_data", bus0.tx_data, 8'h00);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_overrun", bus0.overrun, 0);
    chk("rst_valid_raw", bus1.tx_valid, 0);
    rst = 1'b1;

    // abc digest, no backpressure, both instances side by side
    @(posedge clk); #1;
    push_frame(0, ABC, 1'b1, 1'b1);
    push_frame(1, ABC, 1'b0, 1'b0);
    hs_s = hs0; hs1_s = hs1;
    bus0.digest_in = ABC; bus0.digest_valid = 1'b1;
    bus1.digest_in = ABC; bus1.digest_valid = 1'b1;
    c_e = cyc;
    @(posedge clk); #1;
    bus0.digest_valid = 1'b0; bus1.digest_valid = 1'b0;
    chk("first_valid", bus0.tx_valid, 1);
    chk("first_busy", bus0.busy, 1);
    chk("first_hex", bus0.tx_data, 8'h62);
    chk("first_raw", bus1.tx_data, 8'hBA);
    wait_done0("done_hex", 200);
    chk("lat_hex", done0_cyc - c_e, 67);
    chk("lat_raw", done1_cyc - c_e, 33);
    chk("hs_hex", hs0 - hs_s, 66);
    chk("hs_raw", hs1 - hs1_s, 32);
    chk("idle_busy", bus0.busy, 0);

    // random backpressure
    rdy_mode = 1'b1;
    push_frame(0, ABC, 1'b1, 1'b1);
    hs_s = hs0;
    cap0(ABC);
    wait_done0("done_bp", 2000);
    chk("hs_bp", hs0 - hs_s, 66);
    rdy_mode = 1'b0;
    @(posedge clk); #1;

    // overrun at byte 10, then back-to-back capture in the done cycle
    push_frame(0, ABC, 1'b1, 1'b1);
    hs_s = hs0; ovr_s = ovr0;
    cap0(ABC);
    wait_hs0("hs_to_10", hs_s, 10);
    bus0.digest_in = ONES; bus0.digest_valid = 1'b1;
    @(posedge clk); #1;
    bus0.digest_valid = 1'b0;
    for (int i = 0; i < 200 && !bus0.done; i++) @(posedge clk) #1;
    chk("done_seen", bus0.done, 1);
    push_frame(0, ZERO, 1'b1, 1'b1);
    hs_s = hs0;
    bus0.digest_in = ZERO; bus0.digest_valid = 1'b1;
    @(posedge clk); #1;
    bus0.digest_valid = 1'b0;
    chk("b2b_valid", bus0.tx_valid, 1);
    chk("b2b_data", bus0.tx_data, 8'h30);
    chk("ovr_cnt", ovr0 - ovr_s, 1);
    wait_done0("done_zero", 200);
    chk("hs_zero", hs0 - hs_s, 66);

    // reset mid-frame at byte 20
    @(posedge clk); #1;
    push_frame(0, ABC, 1'b1, 1'b1);
    hs_s = hs0;
    cap0(ABC);
    wait_hs0("hs_to_20", hs_s, 20);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", bus0.tx_valid, 0);
    chk("abort_busy", bus0.busy, 0);
    chk("abort_data", bus0.tx_data, 8'h00);
    chk("abort_done", bus0.done, 0);
    rst = 1'b1;
    q0.delete();
    d_s = done0_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done0_cnt - d_s, 0);

    push_frame(0, ONES, 1'b1, 1'b1);
    hs_s = hs0;
    cap0(ONES);
    chk("ones_first", bus0.tx_data, 8'h66);
    wait_done0("done_ones", 200);
    chk("hs_ones", hs0 - hs_s, 66);

    repeat (3) @(posedge clk);
    #1;
    chk("q_hex_empty", q0.size(), 0);
    chk("q_raw_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
